apb_ap_mst: RTL and testbench
=============================

APB_AP_MST -- requirements
Module: apb_ap_mst

Interface
REQ-001 Parameters SHALL be:
- CNT_W, 6: width of req_cnt (beats minus one).
- TMO_CYC, 255: pready-low cycles before timeout abort (used only with DAP_APB_TMO_EN).

REQ-002 Clock and reset SHALL be one clock, `clk`, and a synchronous active-high reset, `rst`:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.

REQ-003 Request port SHALL be:
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when high with req_valid.
- req_addr  in  32  start byte address.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  32  write data, repeated on every beat.
- req_cnt  in  CNT_W  beats minus one.
- req_prot  in  3  requested pprot.

REQ-004 Gating and status ports SHALL be:
- deviceen  in  1  access enable.
- spiden  in  1  secure access enable.
- busy  out  1  state not IDLE.

REQ-005 APB master port SHALL be:
- m_psel  out  1
- m_penable  out  1
- m_paddr  out  32
- m_pwrite  out  1
- m_pwdata  out  32
- m_pstrb  out  4
- m_pprot  out  3
- m_prdata  in  32
- m_pready  in  1
- m_pslverr  in  1

REQ-006 Result push port, feeding the clock-domain-crossing read-data and response FIFOs, SHALL be:
- buf_push  out  1  one-cycle push per beat.
- buf_wdata  out  32  beat read data.
- buf_wresp  out  2  beat response code.

Function
REQ-007 The FSM SHALL have states IDLE, SETUP, ACCESS and FLUSH; req_ready SHALL be 1 only in IDLE, and busy SHALL equal (state != IDLE).

REQ-008 On req_valid&req_ready, the block SHALL latch addr (with bits [1:0] forced to 0), write, wdata, prot and remaining = req_cnt.
- If deviceen = 1, next state SHALL be SETUP.
- Else next state SHALL be FLUSH with code 2'b11.

REQ-009 In SETUP, outputs SHALL be m_psel=1 and m_penable=0; next state SHALL be ACCESS unconditionally.

REQ-010 In ACCESS, outputs SHALL be m_psel=1 and m_penable=1; the block SHALL hold all APB outputs stable until m_pready=1.

REQ-011 On the ACCESS cycle with m_pready=1, the block SHALL register a push for the next cycle:
- buf_push = 1.
- buf_wdata = m_prdata on reads, 32'h0 on writes.
- buf_wresp = 2'b10 if m_pslverr, else 2'b00.

REQ-012 After each completed beat:
- The address SHALL advance by 4, wrapping modulo 2^32.
- If remaining = 0, next state SHALL be IDLE.
- Else remaining SHALL decrement and next state SHALL be SETUP.
- A slave error SHALL NOT abort the burst.

REQ-013 Minimum beat cost SHALL be 2 cycles: request accepted at cycle 0, psel at cycle 1, penable at cycle 2, and with pready at cycle 2, buf_push at cycle 3.

REQ-014 m_pstrb SHALL be 4'hF on writes and 4'h0 on reads.

REQ-015 m_pprot SHALL be req_prot, except that m_pprot[1] SHALL be forced to 1 (non-secure) when spiden = 0 at request acceptance.

REQ-016 In FLUSH, the block SHALL:
- Drive m_psel = 0.
- Push one entry per cycle with buf_wdata = 0 and buf_wresp = latched code, for remaining+1 entries.
- Then return to IDLE.

REQ-017 Every accepted request SHALL produce exactly req_cnt+1 pushes, in address order.

REQ-018 Changes of deviceen or spiden after acceptance SHALL NOT affect the request in flight.

REQ-019 buf_wdata and buf_wresp SHALL be 0 whenever buf_push = 0.

Reset
REQ-020 While rst = 1, the block SHALL hold:
- state = IDLE.
- All outputs 0, except req_ready = 1.
- Internal counters and registers 0.
- buf_push = 0.

REQ-021 rst asserted mid-burst SHALL abandon the burst next cycle without a push and without completing the APB access.

Configuration
REQ-022 With DAP_APB_TMO_EN defined, the block SHALL count ACCESS cycles with m_pready = 0; on reaching TMO_CYC, it SHALL:
- Drop m_psel and m_penable.
- Enter FLUSH with code 2'b01 covering the current beat plus the remaining beats.

REQ-023 With DAP_APB_TMO_EN undefined, ACCESS SHALL wait indefinitely for m_pready, and code 2'b01 SHALL never be produced.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Single read: addr 0x1000_0006, cnt 0, pready at first ACCESS, prdata 0xDEADBEEF -> paddr 0x1000_0004, one push {0xDEADBEEF, 2'b00} at cycle 3.
- Write burst: addr 0x2000_0000, cnt 3, wdata 0x55, pslverr on beat 2 -> paddr 0x…00, 04, 08, 0C with pstrb 0xF; pushes with resp 00, 00, 10, 00.
- Denied: deviceen = 0, cnt 2 -> no psel; 3 consecutive pushes with resp 2'b11.
- Wrap and secure: addr 0xFFFF_FFFC, cnt 1, spiden = 0, prot 3'b000 -> paddr 0xFFFF_FFFC then 0x0000_0000; pprot 3'b010.
- Timeout (macro on, TMO_CYC = 4): pready held 0, cnt 1 -> psel drops after 4 wait cycles; 2 pushes with resp 2'b01; then IDLE.
- Reset mid-burst: rst asserted in ACCESS of beat 1 of a 4-beat read -> next cycle psel = 0, busy = 0, req_ready = 1, no further pushes.

Source files
------------

// File: rtl/apb_ap_mst_if.sv
// APB bus bundle between the access-port master and its slave.
//   master modport: drives psel/penable/paddr/pwrite/pwdata/pstrb/pprot,
//                   samples prdata/pready/pslverr.
//   slave modport : the mirror image.
interface apb_ap_mst_if;
  logic        m_psel;
  logic        m_penable;
  logic [31:0] m_paddr;
  logic        m_pwrite;
  logic [31:0] m_pwdata;
  logic [3:0]  m_pstrb;
  logic [2:0]  m_pprot;
  logic [31:0] m_prdata;
  logic        m_pready;
  logic        m_pslverr;

  modport master (
    output m_psel, m_penable, m_paddr, m_pwrite, m_pwdata, m_pstrb, m_pprot,
    input  m_prdata, m_pready, m_pslverr
  );

  modport slave (
    input  m_psel, m_penable, m_paddr, m_pwrite, m_pwdata, m_pstrb, m_pprot,
    output m_prdata, m_pready, m_pslverr
  );
endinterface

// File: rtl/apb_ap_mst.sv
// APB burst master for the debug access port.
// Accepts a burst request (start address, direction, beat count), runs one
// APB transfer per beat at incrementing word addresses and pushes one result
// entry per beat toward the clock-crossing read-data/response FIFOs.
// Denied requests (deviceen low) are answered with error entries only.
//
// Ports:
//   clk, rst                 sole clock, synchronous active-high reset
//   req_*                    burst request handshake and attributes
//   deviceen, spiden         access / secure-access enables, sampled at accept
//   busy                     high whenever the FSM is not idle
//   m_apb (master modport)   APB master bus
//   buf_push/wdata/wresp     one-cycle push per beat
//
// Optional build macro: DAP_APB_TMO_EN -- aborts a beat after TMO_CYC
// pready-low ACCESS cycles and flushes the rest of the burst with code 2'b01.
//
// state  | meaning
// IDLE   | ready for a request
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase, waiting for pready
// FLUSH  | no bus activity, one error push per remaining beat
module apb_ap_mst #(
  parameter int CNT_W   = 6,
  parameter int TMO_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic             req_write,
  input  logic [31:0]      req_wdata,
  input  logic [CNT_W-1:0] req_cnt,
  input  logic [2:0]       req_prot,
  input  logic             deviceen,
  input  logic             spiden,
  output logic             busy,
  apb_ap_mst_if.master     m_apb,
  output logic             buf_push,
  output logic [31:0]      buf_wdata,
  output logic [1:0]       buf_wresp
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  logic [1:0]       state_q;
  logic [31:0]      addr_q;
  logic             write_q;
  logic [31:0]      wdata_q;
  logic [2:0]       prot_q;
  logic [CNT_W-1:0] rem_q;
  logic [1:0]       code_q;

`ifdef DAP_APB_TMO_EN
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  logic [TMO_W-1:0] tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo = (TMO_CYC != 0);
`endif

  // Byte-lane bits of the start address are discarded: transfers are word-aligned.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

  // All APB outputs come straight from registers that only move outside
  // ACCESS, so they are stable for the whole wait phase.
  assign m_apb.m_psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign m_apb.m_penable = (state_q == S_ACCESS);
  assign m_apb.m_paddr   = addr_q;
  assign m_apb.m_pwrite  = write_q;
  assign m_apb.m_pwdata  = wdata_q;
  assign m_apb.m_pstrb   = {4{write_q}};
  assign m_apb.m_pprot   = prot_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prot_q    <= '0;
      rem_q     <= '0;
      code_q    <= '0;
      buf_push  <= 1'b0;
      buf_wdata <= '0;
      buf_wresp <= '0;
`ifdef DAP_APB_TMO_EN
      tmo_q     <= '0;
`endif
    end else begin
      // Push outputs default to zero so data/resp are clean between pushes.
      buf_push  <= 1'b0;
      buf_wdata <= '0;
      buf_wresp <= '0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= {req_addr[31:2], 2'b00};
            write_q <= req_write;
            wdata_q <= req_wdata;
            // Without secure enable the access is forced non-secure.
            prot_q  <= {req_prot[2], req_prot[1] | ~spiden, req_prot[0]};
            rem_q   <= req_cnt;
            if (deviceen) begin
              state_q <= S_SETUP;
            end else begin
              state_q <= S_FLUSH;
              code_q  <= 2'b11;
            end
          end
        end
        S_SETUP: begin
          state_q <= S_ACCESS;
`ifdef DAP_APB_TMO_EN
          tmo_q   <= TMO_W'(TMO_CYC - 1);
`endif
        end
        S_ACCESS: begin
          if (m_apb.m_pready) begin
            buf_push  <= 1'b1;
            buf_wdata <= write_q ? 32'h0 : m_apb.m_prdata;
            buf_wresp <= m_apb.m_pslverr ? 2'b10 : 2'b00;
            addr_q    <= addr_q + 32'd4;
            if (rem_q == '0) begin
              state_q <= S_IDLE;
            end else begin
              rem_q   <= rem_q - 1'b1;
              state_q <= S_SETUP;
            end
          end
`ifdef DAP_APB_TMO_EN
          // rem_q is not decremented here, so the flush covers this beat too.
          else if (tmo_q == '0) begin
            state_q <= S_FLUSH;
            code_q  <= 2'b01;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
`endif
        end
        S_FLUSH: begin
          buf_push  <= 1'b1;
          buf_wresp <= code_q;
          if (rem_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_ap_mst.sv
module tb_apb_ap_mst;

  localparam int CNT_W = 6;
  localparam int TMO   = 4;
`ifdef DAP_APB_TMO_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_addr = '0;
  logic             req_write = 1'b0;
  logic [31:0]      req_wdata = '0;
  logic [CNT_W-1:0] req_cnt = '0;
  logic [2:0]       req_prot = '0;
  logic             deviceen = 1'b1;
  logic             spiden = 1'b1;
  logic             busy;
  logic             buf_push;
  logic [31:0]      buf_wdata;
  logic [1:0]       buf_wresp;

  apb_ap_mst_if apb ();

  apb_ap_mst #(.CNT_W(CNT_W), .TMO_CYC(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .req_cnt   (req_cnt),
    .req_prot  (req_prot),
    .deviceen  (deviceen),
    .spiden    (spiden),
    .busy      (busy),
    .m_apb     (apb),
    .buf_push  (buf_push),
    .buf_wdata (buf_wdata),
    .buf_wresp (buf_wresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [31:0] w; logic [31:0] rd; logic e; } beat_t;
  typedef struct packed { logic [31:0] a; logic wr; logic [31:0] wd; logic [2:0] prot; } apb_t;
  typedef struct packed { logic [31:0] d; logic [1:0] r; } push_t;

  beat_t plan_q[$];
  apb_t  exp_apb[$];
  push_t exp_push[$];
  int    push_cyc_q[$];
  int    total = 0;
  int    bad = 0;
  int    acc_run = 0;
  int    last_acc_run = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail(string name, string what);
    total++;
    bad++;
    $display("FAIL %s: %s", name, what);
  endfunction

  // APB slave: follows the per-beat plan (wait cycles, read data, error).
  initial begin
    beat_t cur;
    bit have_cur;
    have_cur = 0;
    cur = '0;
    apb.m_pready  = 1'b0;
    apb.m_prdata  = '0;
    apb.m_pslverr = 1'b0;
    forever begin
      @(negedge clk);
      if (apb.m_psel && apb.m_penable) begin
        if (!have_cur) begin
          if (plan_q.size() != 0) cur = plan_q.pop_front();
          else cur = '0;
          have_cur = 1;
        end
        if (cur.w != 0) begin
          apb.m_pready  = 1'b0;
          apb.m_prdata  = $urandom;
          apb.m_pslverr = 1'($urandom);
          cur.w = cur.w - 1;
        end else begin
          apb.m_pready  = 1'b1;
          apb.m_prdata  = cur.rd;
          apb.m_pslverr = cur.e;
          have_cur = 0;
        end
      end else begin
        have_cur = 0;
        apb.m_pready  = 1'($urandom);
        apb.m_prdata  = $urandom;
        apb.m_pslverr = 1'($urandom);
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    apb_t  ea;
    push_t ep;
    logic [31:0] setup_addr;
    setup_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("busy_vs_ready", busy, !req_ready);
        if (apb.m_penable) chk("penable_needs_psel", apb.m_psel, 1'b1);
        if (apb.m_psel && !apb.m_penable) begin
          if (exp_apb.size() == 0) begin
            fail("apb_setup", "got setup, expected none");
          end else begin
            ea = exp_apb.pop_front();
            chk("paddr", apb.m_paddr, ea.a);
            chk("pwrite", apb.m_pwrite, ea.wr);
            chk("pstrb", apb.m_pstrb, ea.wr ? 4'hF : 4'h0);
            chk("pprot", apb.m_pprot, ea.prot);
            if (ea.wr) chk("pwdata", apb.m_pwdata, ea.wd);
          end
          setup_addr = apb.m_paddr;
        end
        if (apb.m_psel && apb.m_penable) begin
          chk("paddr_stable", apb.m_paddr, setup_addr);
          acc_run++;
        end else if (acc_run != 0) begin
          last_acc_run = acc_run;
          acc_run = 0;
        end
        if (buf_push) begin
          push_cyc_q.push_back(cyc);
          if (exp_push.size() == 0) begin
            fail("push", "got push, expected none");
          end else begin
            ep = exp_push.pop_front();
            chk("buf_wdata", buf_wdata, ep.d);
            chk("buf_wresp", buf_wresp, ep.r);
          end
        end else begin
          chk("idle_wdata_zero", buf_wdata, 32'h0);
          chk("idle_wresp_zero", buf_wresp, 2'b00);
        end
      end
    end
  end

  // Issues one request and records what the spec says must come out of it.
  // wfix < 0: random wait states; err_beat -2: random errors, -1: none.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input int cnt, input logic [2:0] prot, input logic dev,
                       input logic spi, input int err_beat, input int wfix,
                       input logic [31:0] rd0, input bit rd_fix, output int c0);
    logic [31:0] base;
    logic [2:0]  pe;
    beat_t b;
    apb_t  a;
    push_t p;
    int    n;
    c0 = 0;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail("req_ready_wait", "got ready=0 after 500 cycles, expected 1");
      return;
    end
    base = {addr[31:2], 2'b00};
    pe   = spi ? prot : (prot | 3'b010);
    for (int i = 0; i <= cnt; i++) begin
      if (!dev) begin
        p.d = 32'h0; p.r = 2'b11;
        exp_push.push_back(p);
        continue;
      end
      b.w  = (wfix >= 0) ? wfix : $urandom_range(0, TMO_ON ? 5 : 2);
      b.rd = rd_fix ? rd0 + i : $urandom;
      b.e  = (err_beat == -2) ? ($urandom_range(0, 5) == 0) : (i == err_beat);
      plan_q.push_back(b);
      a.a = base + (32'(i) << 2); a.wr = wr; a.wd = wd; a.prot = pe;
      exp_apb.push_back(a);
      if (TMO_ON && b.w >= TMO) begin
        for (int j = i; j <= cnt; j++) begin
          p.d = 32'h0; p.r = 2'b01;
          exp_push.push_back(p);
        end
        break;
      end
      p.d = wr ? 32'h0 : b.rd;
      p.r = b.e ? 2'b10 : 2'b00;
      exp_push.push_back(p);
    end
    req_addr  = addr;
    req_write = wr;
    req_wdata = wd;
    req_cnt   = CNT_W'(cnt);
    req_prot  = prot;
    deviceen  = dev;
    spiden    = spi;
    req_valid = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    deviceen  = 1'($urandom);
    spiden    = 1'($urandom);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_push.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk({name, "_pushes_left"}, exp_push.size(), 0);
    chk({name, "_setups_left"}, exp_apb.size(), 0);
    chk({name, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int c0;
    int n;
    #500_000;
    $display("FAIL watchdog: got no finish, expected finish within 50000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_psel", apb.m_psel, 1'b0);
    chk("rst_penable", apb.m_penable, 1'b0);
    chk("rst_paddr", apb.m_paddr, 32'h0);
    chk("rst_pwrite", apb.m_pwrite, 1'b0);
    chk("rst_pwdata", apb.m_pwdata, 32'h0);
    chk("rst_pstrb", apb.m_pstrb, 4'h0);
    chk("rst_pprot", apb.m_pprot, 3'b000);
    chk("rst_buf_push", buf_push, 1'b0);
    chk("rst_buf_wdata", buf_wdata, 32'h0);
    chk("rst_buf_wresp", buf_wresp, 2'b00);
    rst = 1'b0;

    // Single read, zero wait states: push lands on cycle 3.
    push_cyc_q.delete();
    issue(32'h1000_0006, 1'b0, 32'h0, 0, 3'b000, 1'b1, 1'b1, -1, 0, 32'hDEAD_BEEF, 1, c0);
    drain("single");
    chk("single_npush", push_cyc_q.size(), 1);
    if (push_cyc_q.size() != 0) chk("single_latency", push_cyc_q[0] - c0, 3);

    // Write burst with slave error on beat 2.
    issue(32'h2000_0000, 1'b1, 32'h55, 3, 3'b001, 1'b1, 1'b1, 2, -1, 32'h0, 0, c0);
    drain("wrburst");

    // Denied: three back-to-back error pushes, no bus activity.
    push_cyc_q.delete();
    issue(32'h3000_0010, 1'b0, 32'h0, 2, 3'b000, 1'b0, 1'b1, -1, 0, 32'h0, 0, c0);
    drain("denied");
    chk("denied_npush", push_cyc_q.size(), 3);
    if (push_cyc_q.size() == 3) chk("denied_consecutive", push_cyc_q[2] - push_cyc_q[0], 2);

    // Address wrap, non-secure forcing.
    issue(32'hFFFF_FFFC, 1'b0, 32'h0, 1, 3'b000, 1'b1, 1'b0, -1, -1, 32'hA5A5_0000, 1, c0);
    drain("wrap");

    // Wait-state boundary: 3 waits always complete; 6 waits time out only with the timer.
    last_acc_run = 0;
    issue(32'h4000_0100, 1'b0, 32'h0, 0, 3'b100, 1'b1, 1'b1, -1, 3, 32'h1234_5678, 1, c0);
    drain("wait3");
    chk("wait3_access_len", last_acc_run, 4);
    issue(32'h4000_0200, 1'b1, 32'h77, 0, 3'b000, 1'b1, 1'b1, -1, 6, 32'h0, 0, c0);
    drain("wait6");
    chk("wait6_access_len", last_acc_run, TMO_ON ? 4 : 7);

`ifdef DAP_APB_TMO_EN
    // Timeout on beat 0 of two: psel drops after 4 wait cycles, two 2'b01 pushes.
    last_acc_run = 0;
    push_cyc_q.delete();
    issue(32'h5000_0000, 1'b0, 32'h0, 1, 3'b000, 1'b1, 1'b1, -1, 1000, 32'h0, 0, c0);
    drain("timeout");
    chk("timeout_access_len", last_acc_run, 4);
    chk("timeout_npush", push_cyc_q.size(), 2);
`endif

    // Reset during ACCESS of beat 1 of a 4-beat read.
    issue(32'h6000_0000, 1'b0, 32'h0, 3, 3'b000, 1'b1, 1'b1, -1, 3, 32'h0, 0, c0);
    n = 0;
    while (!(apb.m_psel && apb.m_penable && apb.m_paddr == 32'h6000_0004) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail("rst_mid_wait", "got no ACCESS of beat 1, expected one");
    @(negedge clk);
    rst = 1'b1;
    exp_push.delete();
    exp_apb.delete();
    plan_q.delete();
    @(negedge clk);
    chk("midrst_psel", apb.m_psel, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b1);
    chk("midrst_push", buf_push, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_hold_push", buf_push, 1'b0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_idle_after", busy, 1'b0);

    // Randomized requests.
    for (int k = 0; k < 40; k++) begin
      issue($urandom, 1'($urandom), $urandom, $urandom_range(0, 7), 3'($urandom),
            ($urandom_range(0, 7) != 0), 1'($urandom), -2, -1, 32'h0, 0, c0);
    end
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
